// File: rtl/mem_arb2.sv
// mem_arb2: two-port arbiter in front of the shared MEM/SRAM controller.
// Port 0 (screen refresh) has priority; port 1 (CPU) has a starvation limiter.
//
// Ports:
//  clk, rst               clock, async active-high reset
//  sN_req_*  (N=0,1)      requester side: vld/gnt, addr, wr, dat_strb, dat
//  sN_rsp_*  (N=0,1)      read response: vld/gnt, dat
//  m_req_*                muxed request to MEM: vld/gnt, addr, wr, dat_strb, dat
//  m_rsp_*                response from MEM: vld/gnt, dat
module mem_arb2 #(
  parameter int AW       = 21,
  parameter int DW       = 32,
  parameter int SW       = 4,
  parameter int OUTST    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s0_req_vld,
  output logic          s0_req_gnt,
  input  logic [AW-1:0] s0_req_addr,
  input  logic          s0_req_wr,
  input  logic [SW-1:0] s0_req_dat_strb,
  input  logic [DW-1:0] s0_req_dat,
  output logic          s0_rsp_vld,
  input  logic          s0_rsp_gnt,
  output logic [DW-1:0] s0_rsp_dat,
  input  logic          s1_req_vld,
  output logic          s1_req_gnt,
  input  logic [AW-1:0] s1_req_addr,
  input  logic          s1_req_wr,
  input  logic [SW-1:0] s1_req_dat_strb,
  input  logic [DW-1:0] s1_req_dat,
  output logic          s1_rsp_vld,
  input  logic          s1_rsp_gnt,
  output logic [DW-1:0] s1_rsp_dat,
  output logic          m_req_vld,
  input  logic          m_req_gnt,
  output logic [AW-1:0] m_req_addr,
  output logic          m_req_wr,
  output logic [SW-1:0] m_req_dat_strb,
  output logic [DW-1:0] m_req_dat,
  input  logic          m_rsp_vld,
  output logic          m_rsp_gnt,
  input  logic [DW-1:0] m_rsp_dat
);

  localparam int PW  = $clog2(OUTST);
  localparam int CW  = PW + 1;
  localparam int WCW = $clog2(MAX_WAIT + 1);

  localparam logic [CW-1:0]  FULL_CNT = CW'(OUTST);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

  logic             sel;
  logic             sel_rd;
  logic             stall;
  logic             xfer;
  logic             push;
  logic             pop;
  logic             head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [OUTST-1:0] ids;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic [WCW-1:0]   wait_cnt;
  logic [WCW-1:0]   wait_nxt;
  logic             force_p1;

  assign fifo_full  = (cnt == FULL_CNT);
  assign fifo_empty = (cnt == '0);
  assign head       = ids[rd_ptr];
  assign wait_nxt   = wait_cnt + WCW'(1);

  always_comb begin
    sel    = s1_req_vld & (force_p1 | ~s0_req_vld);
    sel_rd = sel ? ~s1_req_wr : ~s0_req_wr;
    // full uses the registered count: a same-cycle pop does not free a slot
    stall  = fifo_full & sel_rd;

    m_req_vld      = (s0_req_vld | s1_req_vld) & ~stall;
    m_req_addr     = sel ? s1_req_addr     : s0_req_addr;
    m_req_wr       = sel ? s1_req_wr       : s0_req_wr;
    m_req_dat_strb = sel ? s1_req_dat_strb : s0_req_dat_strb;
    m_req_dat      = sel ? s1_req_dat      : s0_req_dat;

    xfer       = m_req_vld & m_req_gnt;
    s0_req_gnt = ~sel & xfer;
    s1_req_gnt = sel & xfer;
    push       = xfer & ~m_req_wr;

    s0_rsp_vld = m_rsp_vld & ~fifo_empty & ~head;
    s1_rsp_vld = m_rsp_vld & ~fifo_empty & head;
    m_rsp_gnt  = ~fifo_empty & (head ? s1_rsp_gnt : s0_rsp_gnt);
    pop        = m_rsp_vld & m_rsp_gnt;

    s0_rsp_dat = m_rsp_dat;
    s1_rsp_dat = m_rsp_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ids    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        ids[wr_ptr] <= sel;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // force_p1 survives a stalled port-1 read; only a port-1 grant
  // or port 1 going idle releases it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      force_p1 <= 1'b0;
    end else if (s1_req_gnt | ~s1_req_vld) begin
      wait_cnt <= '0;
      force_p1 <= 1'b0;
    end else if (s0_req_gnt) begin
      wait_cnt <= wait_nxt;
      if (wait_nxt == WAIT_MAX) begin
        force_p1 <= 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  a_rsp_no_id: assert property (
    @(posedge clk) disable iff (rst)
    m_rsp_vld |-> !fifo_empty);

  a_hold0: assert property (
    @(posedge clk) disable iff (rst)
    s0_req_vld && !s0_req_gnt |=> s0_req_vld &&
      $stable({s0_req_addr, s0_req_wr, s0_req_dat_strb, s0_req_dat}));

  a_hold1: assert property (
    @(posedge clk) disable iff (rst)
    s1_req_vld && !s1_req_gnt |=> s1_req_vld &&
      $stable({s1_req_addr, s1_req_wr, s1_req_dat_strb, s1_req_dat}));
`endif

endmodule
